// File: rtl/keyboard_direction_queue_pkg.sv
// Shared key codes, FSM encoding and direction helpers for the keypad direction queue.
// Used by the top level filter/FSM and by anything that needs to classify keypad codes.
package keyboard_pkg;

  // Keypad ASCII codes, laid out like a numeric keypad
  localparam logic [7:0] KEY_UP         = 8'h38;
  localparam logic [7:0] KEY_DOWN       = 8'h32;
  localparam logic [7:0] KEY_LEFT       = 8'h34;
  localparam logic [7:0] KEY_RIGHT      = 8'h36;
  localparam logic [7:0] KEY_UP_LEFT    = 8'h37;
  localparam logic [7:0] KEY_UP_RIGHT   = 8'h39;
  localparam logic [7:0] KEY_DOWN_LEFT  = 8'h31;
  localparam logic [7:0] KEY_DOWN_RIGHT = 8'h33;
  localparam logic [7:0] KEY_MIDDLE     = 8'h35;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_PAUSED = 1'b1
  } state_t;

  // Keypad codes mirror around '5' (0x35), so the reverse direction is 0x6A - c
  function automatic logic [7:0] opposite_dir(input logic [7:0] c);
    return 8'h6A - c;
  endfunction

  // Orthogonal directions are always legal; diagonals only when enabled
  function automatic logic is_dir(input logic [7:0] c, input logic diag_en);
    logic w_orth;
    logic w_diag;
    w_orth = (c == KEY_UP) || (c == KEY_DOWN) || (c == KEY_LEFT) || (c == KEY_RIGHT);
    w_diag = (c == KEY_UP_LEFT) || (c == KEY_UP_RIGHT) ||
             (c == KEY_DOWN_LEFT) || (c == KEY_DOWN_RIGHT);
    return w_orth || (diag_en && w_diag);
  endfunction

endpackage

// File: rtl/keyboard_direction_queue_dir_fifo.sv
// DEPTH x 8 circular buffer of pending directions with head and tail peek.
// Push and pop take effect at the clock edge; count/full/empty come from registers.
// Pop on empty is ignored; push on full is accepted only together with a pop.
module dir_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_dat,
  output logic [7:0]    o_head,
  output logic [7:0]    o_tail,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_do_pop;
  logic          w_do_push;
  logic [PW-1:0] w_tail_ptr;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign w_do_pop   = i_pop && !o_empty;
  // A full queue still accepts a push when the head leaves on the same edge
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  // DEPTH is a power of two, so the pointer wraps naturally
  assign w_tail_ptr = r_wr_ptr - PW'(1);
  assign o_head     = r_mem[r_rd_ptr];
  assign o_tail     = r_mem[w_tail_ptr];
  assign o_count    = r_count;

  // Storage: entries are only ever read while counted, so no reset is needed
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/keyboard_direction_queue.sv
// Filters keypad direction codes, queues legal changes and applies one per game tick; '5' toggles pause.
// A popped direction appears on dir one edge after the tick; dir_changed pulses in the following cycle.
// No backpressure: keys arriving with a full queue are dropped and flagged in sticky overflow.
module keyboard_direction_queue
  import keyboard_pkg::*;
#(
  parameter  int         DEPTH    = 4,
  parameter  bit         DIAG_EN  = 1'b1,
  parameter  bit         PAUSE_EN = 1'b1,
  parameter  logic [7:0] INIT_DIR = 8'h34,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    word_in,
  input  logic          word_valid,
  input  logic          tick,
  output logic [7:0]    dir,
  output logic          dir_changed,
  output logic          paused,
  output logic [CW-1:0] queue_count,
  output logic          overflow
);

  state_t     r_state;
  logic [7:0] r_dir;
  logic       r_dir_changed;
  logic       r_paused;
  logic       r_overflow;

  logic [7:0]    w_head;
  logic [7:0]    w_tail;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_ref;
  logic          w_run;
  logic          w_pause_key;
  logic          w_dir_key;
  logic          w_push_req;
  logic          w_pop;
  logic          w_drop_full;

  assign w_run       = (r_state == ST_RUN);
  assign w_pause_key = PAUSE_EN && word_valid && (word_in == KEY_MIDDLE);
  assign w_dir_key   = word_valid && is_dir(word_in, DIAG_EN);
  // New keys are judged against the last direction that will be in effect, pre-pop
  assign w_ref       = w_empty ? r_dir : w_tail;
  assign w_pop       = w_run && tick && !w_empty;
  assign w_push_req  = w_run && w_dir_key &&
                       (word_in != w_ref) && (word_in != opposite_dir(w_ref));
  assign w_drop_full = w_push_req && w_full && !w_pop;

  dir_fifo #(
    .DEPTH (DEPTH)
  ) u_dir_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_pop   (w_pop),
    .i_dat   (word_in),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Run/pause FSM plus the applied direction, change pulse and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_dir         <= INIT_DIR;
      r_dir_changed <= 1'b0;
      r_paused      <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_dir_changed <= w_pop;
      if (w_pop) r_dir <= w_head;
      if (w_drop_full) r_overflow <= 1'b1;
      case (r_state)
        ST_RUN: begin
          if (w_pause_key) begin
            r_state  <= ST_PAUSED;
            r_paused <= 1'b1;
          end
        end
        ST_PAUSED: begin
          if (w_pause_key) begin
            r_state  <= ST_RUN;
            r_paused <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_paused <= 1'b0;
        end
      endcase
    end
  end

  assign dir         = r_dir;
  assign dir_changed = r_dir_changed;
  assign paused      = r_paused;
  assign queue_count = w_count;
  assign overflow    = r_overflow;

endmodule

// File: doc/keyboard_direction_queue.md
Name: keyboard_direction_queue

Overview:
Parametrised successor of the single-key direction latch. Accepts keypad ASCII codes ('1'..'9') from the keyboard/UART receiver and filters out reversals and repeats. Buffers legal direction changes in a small FIFO so that fast key sequences within one game step are not lost. Applies exactly one queued direction per game tick, and handles a pause toggle on '5'. Sits between the keyboard receiver and the snake movement logic.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
DIAG_EN, 1, 1 = diagonals '1','3','7','9' accepted; 0 = ignored
PAUSE_EN, 1, 1 = '5' (8'h35) toggles pause; 0 = '5' ignored
INIT_DIR, 8'h34, direction after reset (LEFT); must be a legal direction for the chosen DIAG_EN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
word_in  in  8  received key code
word_valid  in  1  single-cycle strobe: word_in holds a new key
tick  in  1  single-cycle game-step strobe; consumes one queued direction
dir  out  8  current applied direction (ASCII code)
dir_changed  out  1  one-cycle pulse, cycle after dir changes
paused  out  1  1 while in PAUSED state
queue_count  out  $clog2(DEPTH+1)  entries waiting
overflow  out  1  sticky: a legal key was dropped because the queue was full

Behaviour:
- Reset (rst=0, async): dir=INIT_DIR; queue empty; queue_count=0; paused=0; dir_changed=0; overflow=0; state=RUN.
- Legal direction set: 8'h32/34/36/38 always; 8'h31/33/37/39 only if DIAG_EN. Any other code, and '5' when PAUSE_EN=0, is ignored. Ignored codes cause no state change.
- Opposite pairs: opposite(c) = 8'h6A - c (1<->9, 2<->8, 3<->7, 4<->6).
- Reference direction ref = queue tail entry if queue_count>0, else dir. ref is sampled before any same-cycle pop.
- FSM RUN:
  - word_valid and legal code c:
    - c==ref or c==opposite(ref): drop, no flag.
    - Queue not full, or full with simultaneous pop: push c.
    - Otherwise: drop c and set overflow=1.
  - word_valid with '5' and PAUSE_EN: go to PAUSED at the next edge; no push that cycle.
  - tick with queue_count>0: pop head into dir at this edge; dir_changed=1 next cycle for exactly one cycle. tick with an empty queue: dir holds, no pulse.
- FSM PAUSED:
  - tick is ignored (no pop).
  - Direction keys are ignored (not queued, no overflow).
  - '5' returns to RUN at the next edge.
  - The queue contents are preserved across the pause.
- Simultaneous push and tick:
  - The pop takes the head that existed before the push.
  - With an empty queue, a key pushed on the tick cycle is applied on the next tick (latency 1 tick).
  - With a full queue, the push is accepted and queue_count stays DEPTH.
- Pointers wrap modulo DEPTH. queue_count never exceeds DEPTH and never underflows.
- Reset mid-operation clears the queue and the pause state immediately, regardless of state.
- overflow is cleared only by reset.
- All outputs are registered.

Decomposition:
- Shared package keyboard_pkg holds:
  - key code constants: UP 8'h38, DOWN 8'h32, LEFT 8'h34, RIGHT 8'h36, UP_LEFT 8'h37, UP_RIGHT 8'h39, DOWN_LEFT 8'h31, DOWN_RIGHT 8'h33, MIDDLE 8'h35;
  - FSM state encoding (RUN, PAUSED);
  - functions opposite_dir(c) and is_dir(c, diag_en).
- One sub-module, dir_fifo: DEPTH x 8 circular buffer with push, pop, head, tail peek, count and full/empty outputs, plus the same async active-low reset.
- The top level contains the filter, the FSM and the dir/flag registers.

Test Plan:
1. Reset, then tick with no key: dir=8'h34, dir_changed stays 0, queue_count=0.
2. From dir=LEFT, press '8' then '6' in one step, then tick twice: queue holds 38,36. dir becomes 8'h38 on tick 1 and 8'h36 on tick 2, with one dir_changed pulse after each.
3. From dir=LEFT, press '6' (reverse) and '4' (repeat): both dropped, queue_count=0. Then '8','2': '8' accepted, '2' dropped because it is opposite of tail 38.
4. DEPTH=4: push 8,6,2,4 alternating legally, then a fifth legal key: queue_count=4, overflow=1. A fifth key on the same cycle as a tick is accepted instead, with overflow=0.
5. Press '5', press '8', tick: paused=1, queue unchanged, dir unchanged. Press '5' again, then tick: paused=0 and queued entries resume popping.
6. DIAG_EN=0: press '9' -> ignored. DIAG_EN=1 from dir=UP_RIGHT: '1' dropped, '7' accepted. Assert rst=0 mid-queue -> all outputs return to reset values asynchronously.
